// File: rtl/snn_lif_if.sv
// Handshake, weight-programming and spike-FIFO signals of the LIF neuron layer.
// The master side drives events, weights and pops; the slave side is the layer.
interface snn_lif_if #(
   parameter int N_NEURONS  = 16,
   parameter int N_INPUTS   = 16,
   parameter int W_BITS     = 8,
   parameter int V_BITS     = 12,
   parameter int FIFO_DEPTH = 8
);
   localparam int IA_W  = $clog2(N_INPUTS);
   localparam int NA_W  = $clog2(N_NEURONS);
   localparam int WA_W  = $clog2(N_INPUTS * N_NEURONS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                     in_valid;
   logic [IA_W-1:0]          in_addr;
   logic                     in_ready;
   logic signed [V_BITS-1:0] thresh;
   logic                     wt_wen;
   logic [WA_W-1:0]          wt_addr;
   logic signed [W_BITS-1:0] wt_data;
   logic                     busy;
   logic                     spike_ren;
   logic [NA_W-1:0]          spike_addr;
   logic                     spike_empty;
   logic [CNT_W-1:0]         spike_count;

   modport master (
      output in_valid, in_addr, thresh, wt_wen, wt_addr, wt_data, spike_ren,
      input  in_ready, busy, spike_addr, spike_empty, spike_count
   );

   modport slave (
      input  in_valid, in_addr, thresh, wt_wen, wt_addr, wt_data, spike_ren,
      output in_ready, busy, spike_addr, spike_empty, spike_count
   );
endinterface

// File: rtl/snn_lif_layer.sv
// Event-driven integrate-and-fire layer: each accepted event sweeps all neurons one per
// cycle, adding a weight row with saturation and queueing fired neuron indices in a FIFO.
module snn_lif_layer #(
   parameter int N_NEURONS  = 16,
   parameter int N_INPUTS   = 16,
   parameter int W_BITS     = 8,
   parameter int V_BITS     = 12,
   parameter int RESET_MODE = 0,
   parameter int FIFO_DEPTH = 8
) (
   input logic      clk,
   input logic      rst,
   snn_lif_if.slave bus
);
   localparam int IA_W  = $clog2(N_INPUTS);
   localparam int NA_W  = $clog2(N_NEURONS);
   localparam int N_WTS = N_INPUTS * N_NEURONS;
   localparam int WA_W  = $clog2(N_WTS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic signed [V_BITS:0] V_HI = (V_BITS+1)'((1 << (V_BITS-1)) - 1);
   localparam logic signed [V_BITS:0] V_LO = -V_HI - 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   function automatic logic signed [V_BITS-1:0] sat(input logic signed [V_BITS:0] x);
      if (x > V_HI)      return V_HI[V_BITS-1:0];
      else if (x < V_LO) return V_LO[V_BITS-1:0];
      else               return x[V_BITS-1:0];
   endfunction

   state_t                   state, state_nxt;
   logic [IA_W-1:0]          ch;
   logic [NA_W-1:0]          k;
   logic signed [W_BITS-1:0] wt  [N_WTS];
   logic signed [V_BITS-1:0] pot [N_NEURONS];
   logic [NA_W-1:0]          fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]         rd_ptr, wr_ptr;
   logic [CNT_W-1:0]         count;

   logic                     start, last, fire, full, stall, advance, push, pop;
   logic [WA_W-1:0]          rd_idx;
   logic signed [W_BITS-1:0] w_sel;
   logic signed [V_BITS:0]   sum_wide, diff_wide;
   logic signed [V_BITS-1:0] sum_sat, pot_nxt;

   // Neuron update datapath; the weight read sees the pre-edge array, so a same-cycle
   // write to that entry only affects later sweeps.
   always_comb begin
      // NOTE: every combinational output gets a value on every path, so no latch is inferred.
      rd_idx    = WA_W'(ch) * WA_W'(N_NEURONS) + WA_W'(k);
      w_sel     = wt[rd_idx];
      sum_wide  = (V_BITS+1)'(pot[k]) + (V_BITS+1)'(w_sel);
      sum_sat   = sat(sum_wide);
      diff_wide = (V_BITS+1)'(sum_sat) - (V_BITS+1)'(bus.thresh);
      fire      = (state == ACCUM) && (sum_sat >= bus.thresh);
      pot_nxt   = fire ? ((RESET_MODE != 0) ? sat(diff_wide) : '0) : sum_sat;
      full      = (count == CNT_W'(FIFO_DEPTH));
      stall     = fire && full;
      advance   = (state == ACCUM) && !stall;
      push      = fire && !full;
      pop       = bus.spike_ren && (count != '0);
      start     = bus.in_valid && (state == IDLE) && (32'(bus.in_addr) < N_INPUTS);
      last      = (k == NA_W'(N_NEURONS - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (advance && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state == IDLE);
      bus.busy     = (state != IDLE);
   end

   // Out-of-range event channels complete the handshake in IDLE but never start a sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch <= '0;
         k  <= '0;
      end else if (start) begin
         ch <= bus.in_addr;
         k  <= '0;
      end else if (advance) begin
         k  <= k + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_NEURONS; i++) pot[i] <= '0;
      end else if (advance) begin
         pot[k] <= pot_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_WTS; i++) wt[i] <= '0;
      end else if (bus.wt_wen && (32'(bus.wt_addr) < N_WTS)) begin
         wt[bus.wt_addr] <= bus.wt_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; entries are only visible once the pointers cover them.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= k;
   end

   always_comb begin
      bus.spike_empty = (count == '0);
      bus.spike_addr  = (count == '0) ? '0 : fifo[rd_ptr];
      bus.spike_count = count;
   end
endmodule

// File: tb/tb_snn_lif_layer.sv
// Drives one stimulus stream into a reset-to-zero and a subtract-threshold layer and
// compares potentials and drained spikes against an event-level arithmetic model.
module tb_snn_lif_layer;
   localparam int NN = 16, NI = 12, WB = 8, VB = 12, FD = 8;
   localparam int VMAX = 2047, VMIN = -2048;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic              in_valid;
   logic [3:0]        in_addr;
   logic signed [11:0] thresh;
   logic              wt_wen;
   logic [7:0]        wt_addr;
   logic signed [7:0] wt_data;
   logic [1:0]        ren = 2'b00;
   logic [1:0]        rdy, bsy, emp;
   logic [3:0]        sa [2];
   logic [3:0]        sc [2];

   snn_lif_if #(.N_NEURONS(NN), .N_INPUTS(NI), .W_BITS(WB), .V_BITS(VB), .FIFO_DEPTH(FD)) if0 ();
   snn_lif_if #(.N_NEURONS(NN), .N_INPUTS(NI), .W_BITS(WB), .V_BITS(VB), .FIFO_DEPTH(FD)) if1 ();

   assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;
   assign if0.in_addr  = in_addr;   assign if1.in_addr  = in_addr;
   assign if0.thresh   = thresh;    assign if1.thresh   = thresh;
   assign if0.wt_wen   = wt_wen;    assign if1.wt_wen   = wt_wen;
   assign if0.wt_addr  = wt_addr;   assign if1.wt_addr  = wt_addr;
   assign if0.wt_data  = wt_data;   assign if1.wt_data  = wt_data;
   assign if0.spike_ren = ren[0];   assign if1.spike_ren = ren[1];
   assign rdy = {if1.in_ready, if0.in_ready};
   assign bsy = {if1.busy, if0.busy};
   assign emp = {if1.spike_empty, if0.spike_empty};
   assign sa[0] = if0.spike_addr;   assign sa[1] = if1.spike_addr;
   assign sc[0] = if0.spike_count;  assign sc[1] = if1.spike_count;

   snn_lif_layer #(.N_NEURONS(NN), .N_INPUTS(NI), .W_BITS(WB), .V_BITS(VB),
                   .RESET_MODE(0), .FIFO_DEPTH(FD)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   snn_lif_layer #(.N_NEURONS(NN), .N_INPUTS(NI), .W_BITS(WB), .V_BITS(VB),
                   .RESET_MODE(1), .FIFO_DEPTH(FD)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   int n_assert = 0, n_fail = 0;
   int th = 0;
   int mw [NI][NN];
   int mv [2][NN];
   int eq [2][256];
   int eh [2] = '{0, 0};
   int et [2] = '{0, 0};
   bit drain_en = 1'b0;
   int pop_req = 0;
   int pop_done [2] = '{0, 0};

   task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(int x);
      if (x > VMAX) return VMAX;
      if (x < VMIN) return VMIN;
      return x;
   endfunction

   // One whole event at once: potentials after the sweep and the ordered spike list.
   function automatic void model_event(int c);
      int s;
      if (c >= NI) return;
      for (int r = 0; r < 2; r++)
         for (int n = 0; n < NN; n++) begin
            s = clampv(mv[r][n] + mw[c][n]);
            if (s >= th) begin
               eq[r][et[r] % 256] = n;
               et[r]++;
               mv[r][n] = (r == 1) ? clampv(s - th) : 0;
            end else begin
               mv[r][n] = s;
            end
         end
   endfunction

   // Pops spikes (randomly when enabled, or on request) and checks them against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         ren[i] = 1'b0;
         if (!rst && !emp[i] && ((drain_en && $urandom_range(0, 3) != 0) || pop_done[i] < pop_req)) begin
            if (eh[i] == et[i]) check($sformatf("unexpected spike dut%0d", i), sa[i], -1);
            else begin
               check($sformatf("spike dut%0d #%0d", i, eh[i]), sa[i], eq[i][eh[i] % 256]);
               eh[i]++;
            end
            ren[i] = 1'b1;
            if (pop_done[i] < pop_req) pop_done[i]++;
         end
      end
   end

   task automatic set_thresh(int v);
      th = v;
      thresh = v[11:0];
   endtask

   task automatic wr(int idx, int val);
      wt_wen = 1'b1; wt_addr = idx[7:0]; wt_data = val[7:0];
      @(negedge clk);
      wt_wen = 1'b0;
      if (idx < NI * NN) mw[idx / NN][idx % NN] = val;
   endtask

   task automatic send(int c);
      int n = 0;
      while (rdy != 2'b11 && n < 3000) begin @(negedge clk); n++; end
      check("ready before event", n < 3000, 1);
      in_valid = 1'b1; in_addr = c[3:0];
      @(posedge clk);
      model_event(c);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(string tag);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (n < 3000 && !(rdy == 2'b11 && emp == 2'b11 && eh[0] == et[0] && eh[1] == et[1]));
      check($sformatf("%s idle within bound", tag), n < 3000, 1);
   endtask

   task automatic check_pots(string tag);
      for (int r = 0; r < 2; r++)
         for (int n = 0; n < NN; n++)
            check($sformatf("%s pot%0d[%0d]", tag, r, n),
                  (r == 0) ? dut0.pot[n] : dut1.pot[n], mv[r][n]);
   endtask

   task automatic check_idle(string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s in_ready%0d", tag, i), rdy[i], 1);
         check($sformatf("%s busy%0d", tag, i), bsy[i], 0);
         check($sformatf("%s empty%0d", tag, i), emp[i], 1);
         check($sformatf("%s spike_addr%0d", tag, i), sa[i], 0);
         check($sformatf("%s spike_count%0d", tag, i), sc[i], 0);
      end
   endtask

   // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
   task automatic do_reset(string tag);
      #2 rst = 1'b1;
      for (int r = 0; r < 2; r++) begin
         eh[r] = 0; et[r] = 0;
         for (int n = 0; n < NN; n++) mv[r][n] = 0;
      end
      for (int c = 0; c < NI; c++) for (int n = 0; n < NN; n++) mw[c][n] = 0;
      #1;
      check_idle(tag);
      check_pots(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_timed(string tag, int c);
      int rt [2];
      send(c);
      rt[0] = 0; rt[1] = 0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 1) check($sformatf("%s busy in sweep", tag), bsy, 3);
         for (int i = 0; i < 2; i++) if (rdy[i] && rt[i] == 0) rt[i] = n;
         @(negedge clk);
      end
      check($sformatf("%s ready delay dut0", tag), rt[0], 17);
      check($sformatf("%s ready delay dut1", tag), rt[1], 17);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_addr = '0; wt_wen = 1'b0; wt_addr = '0; wt_data = '0;
      set_thresh(0);
      for (int c = 0; c < NI; c++) for (int k = 0; k < NN; k++) mw[c][k] = 0;
      for (int r = 0; r < 2; r++) for (int k = 0; k < NN; k++) mv[r][k] = 0;
      repeat (2) @(negedge clk);
      check_idle("in reset");
      check_pots("in reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_idle("idle after reset");
      drain_en = 1'b1;

      // Single weight: first sweep integrates, second fires neuron 3.
      set_thresh(10);
      wr(1 * NN + 3, 6);
      send_timed("ev1", 1); wait_idle("ev1"); check_pots("ev1");
      send_timed("ev2", 1); wait_idle("ev2"); check_pots("ev2");

      // Subtractive versus zeroing reset over three events.
      do_reset("reset before mode test");
      set_thresh(10);
      wr(5, 7);
      for (int e = 0; e < 3; e++) begin
         send(0); wait_idle("mode"); check_pots($sformatf("mode ev%0d", e));
      end

      // Positive then negative saturation.
      do_reset("reset before saturation");
      set_thresh(2047);
      wr(2 * NN, 127);
      for (int e = 1; e <= 40; e++) begin
         send(2); wait_idle("sat+");
         if (e == 16 || e == 17) check_pots($sformatf("sat+ ev%0d", e));
      end
      check_pots("sat+ end");
      wr(2 * NN, -128);
      for (int e = 1; e <= 30; e++) begin send(2); wait_idle("sat-"); end
      check("sat- floor", dut0.pot[0], VMIN);
      check_pots("sat- end");

      // FIFO-full stall and single-pop resume.
      do_reset("reset before stall");
      set_thresh(1);
      for (int k = 0; k < NN; k++) wr(k, 2);
      drain_en = 1'b0;
      send(0);
      repeat (30) @(negedge clk);
      check("stall busy", bsy, 3);
      check("stall count0", sc[0], FD);
      check("stall count1", sc[1], FD);
      check("stall head", sa[1], 0);
      check("stall pot1[7]", dut1.pot[7], 1);
      check("stall pot1[8] held", dut1.pot[8], 0);
      pop_req++;
      n = 0;
      while ((pop_done[0] != pop_req || pop_done[1] != pop_req) && n < 100) begin #1; n++; end
      check("pop request served", n < 100, 1);
      @(posedge clk); #1;
      check("after pop count", sc[1], FD - 1);
      check("after pop pot1[8]", dut1.pot[8], 0);
      @(posedge clk); #1;
      check("resume pot1[8]", dut1.pot[8], 1);
      check("resume count", sc[1], FD);
      check("resume pot1[9] held", dut1.pot[9], 0);
      @(negedge clk);
      drain_en = 1'b1;
      wait_idle("stall drain");
      check_pots("stall end");

      // Out-of-range channel and out-of-range weight address.
      @(negedge clk);
      in_valid = 1'b1; in_addr = 4'(NI);
      @(posedge clk); #1;
      check("discard ready", rdy, 3);
      check("discard busy", bsy, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wr(200, 55);
      repeat (3) @(negedge clk);
      check("discard still idle", bsy, 0);
      check_pots("discard");

      // Reset in the middle of a sweep.
      set_thresh(100);
      for (int k = 0; k < NN; k++) wr(1 * NN + k, 3);
      send(1); wait_idle("pre abort"); check_pots("pre abort");
      send(1);
      repeat (5) @(negedge clk);
      check("abort busy before reset", bsy, 3);
      do_reset("abort");

      // Weight write landing on the entry being read uses the old value.
      set_thresh(100);
      wr(3 * NN + 4, 5);
      send(3);
      repeat (4) @(negedge clk);
      wr(3 * NN + 4, -20);
      wait_idle("wr race"); check_pots("wr race old");
      send(3); wait_idle("wr race 2"); check_pots("wr race new");

      // Randomised events, weights and thresholds.
      do_reset("reset before random");
      for (int it = 0; it < 25; it++) begin
         for (int j = 0; j < 6; j++) wr($urandom_range(0, NI * NN - 1), int'($urandom_range(0, 255)) - 128);
         if ($urandom_range(0, 4) == 0) set_thresh(int'($urandom_range(0, 4095)) - 2048);
         else set_thresh(int'($urandom_range(0, 300)) - 50);
         send($urandom_range(0, NI + 1));
         wait_idle("random");
         check_pots($sformatf("random it%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
